data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Load/store unit sitting directly upstream of the data-memory BRAM port B in the riscv32i core. It accepts one load or store request at a time from the execute stage over a valid/ready handshake. It rebases the address by `memory_offset`, generates the byte-lane write enables and shifted store data, and drives the BRAM port. It then captures `data_mem_doutb` after the BRAM's one-cycle read latency and returns a sign- or zero-extended result over a valid/ready response channel.

## Interface
- `MEM_DEPTH`, 4096: BRAM depth in 32-bit words; the valid byte range is 0 .. 4*MEM_DEPTH-1 after rebasing.
- `clk` input 1: single clock; all logic rises on posedge.
- `reset` input 1: synchronous, active-high.
- `memory_offset` input 32: base subtracted from every request address; static while requests are in flight.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept; high only in IDLE with `data_mem_rstb_busy`=0.
- `req_we` input 1: 1=store, 0=load.
- `req_funct3` input 3: RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` input 32: byte address before rebasing.
- `req_wdata` input 32: store data, right-aligned.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_rdata` output 32: extended load data; 0 for stores and errors.
- `rsp_err` output 1: out-of-range access, illegal funct3, or misaligned access (see Configuration).
- `data_mem_clkb` output 1: equal to `clk`.
- `data_mem_enb`, `data_mem_rstb` (tied 0), `data_mem_web` [3:0], `data_mem_addrb` [31:0], `data_mem_dinb` [31:0]: outputs to BRAM port B.
- `data_mem_doutb` input 32, `data_mem_rstb_busy` input 1: from BRAM.

## Operation
- FSM states are IDLE, ACCESS, WAIT and RESP; reset forces IDLE.
- **IDLE:** on `req_valid & req_ready`, register `we`, `funct3`, `wdata` and `phys = req_addr - memory_offset` (32-bit wrap).
  - Compute `err` in the same cycle from three conditions: funct3 illegal (011/110/111, or 100/101 with we=1); `phys >= 4*MEM_DEPTH`, unsigned; misalignment (see Configuration).
  - If err, go to RESP with `rsp_err`=1. Otherwise go to ACCESS.
- **ACCESS:** drive the BRAM port for exactly one cycle.
  - `enb`=1 and `addrb = {phys[31:2],2'b00}`.
  - For stores, `web` = 0001<<phys[1:0] (B), 0011<<phys[1] * 2 (H), or 1111 (W). `dinb` = wdata replicated: byte into all four lanes, half into both halves.
  - For loads, `web`=0.
  - Next state is WAIT.
- **WAIT:** `data_mem_doutb` is valid.
  - Select the lane by phys[1:0] (byte) or phys[1] (half). Sign-extend for B/H; zero-extend for BU/HU; pass W through.
  - Register the result into `rsp_rdata` (0 if store) and go to RESP.
- **RESP:** `rsp_valid`=1 with `rsp_rdata` and `rsp_err` held stable. On `rsp_ready`, go to IDLE.
- Outside ACCESS, `enb`=0, `web`=0, `addrb`=0 and `dinb`=0.
- **Reset mid-operation:** abandon the request in the next cycle and discard any pending response. A BRAM write already issued in ACCESS stays committed.

## Timing
- **Reset values:** `req_ready`=0 during the reset cycle and 1 on the following cycle if `rstb_busy`=0; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `enb`=0, `web`=0, `addrb`=0, `dinb`=0, `rstb`=0.
- **Latency:** acceptance edge E0, BRAM access at edge E1, result registered at E2. `rsp_valid` is high from the cycle after E2, i.e. 3 cycles after acceptance for loads and stores alike.
- **Error path:** `rsp_valid` is high in the cycle after E0 (1 cycle); the BRAM is never enabled.
- **Throughput:**
  - One request in flight.
  - `req_ready` is low from ACCESS through RESP.
  - A response accepted at edge Ek allows a new request to be accepted at Ek+1 at the earliest; `req_ready` is combinational on state.
  - With `rsp_ready` tied 1, the minimum request period is 4 cycles.
- **Backpressure:** holding `rsp_ready` low keeps RESP and all response outputs stable indefinitely.
- **rstb_busy:** `rstb_busy`=1 holds `req_ready` low in IDLE. It has no effect on a request already in flight.

## Configuration
- `DATA_MEM_LSU_MISALIGN_TRAP_EN`
  - Defined: an H/HU access with phys[0]=1, or a W access with phys[1:0]≠0, sets `rsp_err`=1 and performs no BRAM access.
  - Undefined: misaligned accesses are silently aligned down. H uses phys[1] and ignores phys[0]; W ignores phys[1:0]. `rsp_err` covers only funct3 and range errors.

## Test plan
- **Word round-trip:** `memory_offset`=0x600, SW addr 0x604 data 0xDEADBEEF, then LW 0x604 -> `web`=1111 and `addrb`=0x4 in ACCESS; load `rsp_rdata`=0xDEADBEEF exactly 3 cycles after acceptance, `rsp_err`=0.
- **Byte store and sign extension:** SB 0x80 to 0x607, then LB 0x607 -> `web`=1000, `dinb`=0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- **Half lanes:** memory word 0x12348765, LH at offset 2 -> 0x00001234; LH at offset 0 -> 0xFFFF8765; LHU at offset 0 -> 0x00008765.
- **Range and illegal funct3:** LW 0x600+4*MEM_DEPTH -> `rsp_err`=1 one cycle after acceptance, `enb` never asserted. SB with funct3=100 -> `rsp_err`=1.
- **Misaligned word:** LW 0x605 -> with the macro defined, `rsp_err`=1 and no access; without it, returns word 0x604 with `rsp_err`=0.
- **Backpressure and reset:** hold `rsp_ready`=0 for 10 cycles -> `rsp_valid`/`rsp_rdata` stable and `req_ready`=0. Assert `reset` in WAIT -> next cycle `rsp_valid`=0; after reset, `req_ready`=1 and the FSM is in IDLE.

Source files
------------

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: one-outstanding load/store unit in front of data-memory BRAM port B.
// Optional define DATA_MEM_LSU_MISALIGN_TRAP_EN makes misaligned H/HU/W accesses return an error.
module data_mem_lsu #(
   parameter int unsigned MEM_DEPTH = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memory_offset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        data_mem_clkb,
   output logic        data_mem_enb,
   output logic        data_mem_rstb,
   output logic [3:0]  data_mem_web,
   output logic [31:0] data_mem_addrb,
   output logic [31:0] data_mem_dinb,
   input  logic [31:0] data_mem_doutb,
   input  logic        data_mem_rstb_busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

   localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_DEPTH);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] phys_q, phys_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] req_phys;
   logic        req_err;
   logic        f3_bad;
   logic        misalign;
   logic        accept;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   assign req_phys = req_addr - memory_offset;
   assign accept   = (state_q == S_IDLE) && req_valid && req_ready;

   // NOTE: every signal assigned in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      f3_bad = 1'b1;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
         3'b100, 3'b101:         f3_bad = req_we;
         default:                f3_bad = 1'b1;
      endcase
      misalign = 1'b0;
`ifdef DATA_MEM_LSU_MISALIGN_TRAP_EN
      case (req_funct3)
         3'b001, 3'b101: misalign = req_phys[0];
         3'b010:         misalign = |req_phys[1:0];
         default:        misalign = 1'b0;
      endcase
`endif
      req_err = f3_bad || (req_phys >= BYTE_LIMIT) || misalign;
   end

   // FSM: state register.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = req_err ? S_RESP : S_ACCESS;
         S_ACCESS: state_d = S_WAIT;
         S_WAIT:   state_d = S_RESP;
         S_RESP:   if (rsp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM: outputs. The BRAM port is quiet everywhere except ACCESS.
   always_comb begin
      req_ready      = (state_q == S_IDLE) && !data_mem_rstb_busy && !reset;
      rsp_valid      = (state_q == S_RESP);
      data_mem_enb   = 1'b0;
      data_mem_web   = 4'b0000;
      data_mem_addrb = 32'h0;
      data_mem_dinb  = 32'h0;
      if (state_q == S_ACCESS) begin
         data_mem_enb   = 1'b1;
         data_mem_addrb = {phys_q[31:2], 2'b00};
         if (we_q) begin
            case (funct3_q[1:0])
               2'b00: begin
                  data_mem_web  = 4'b0001 << phys_q[1:0];
                  data_mem_dinb = {4{wdata_q[7:0]}};
               end
               2'b01: begin
                  data_mem_web  = 4'b0011 << {phys_q[1], 1'b0};
                  data_mem_dinb = {2{wdata_q[15:0]}};
               end
               default: begin
                  data_mem_web  = 4'b1111;
                  data_mem_dinb = wdata_q;
               end
            endcase
         end
      end
   end

   assign rsp_rdata     = rdata_q;
   assign rsp_err       = err_q;
   assign data_mem_clkb = clk;
   assign data_mem_rstb = 1'b0;

   // Lane select and extension of the BRAM read word.
   always_comb begin
      case (phys_q[1:0])
         2'b00:   byte_lane = data_mem_doutb[7:0];
         2'b01:   byte_lane = data_mem_doutb[15:8];
         2'b10:   byte_lane = data_mem_doutb[23:16];
         default: byte_lane = data_mem_doutb[31:24];
      endcase
      half_lane = phys_q[1] ? data_mem_doutb[31:16] : data_mem_doutb[15:0];
      case (funct3_q)
         3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
         3'b100:  load_data = {24'h0, byte_lane};
         3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
         3'b101:  load_data = {16'h0, half_lane};
         default: load_data = data_mem_doutb;
      endcase
   end

   always_comb begin
      we_d     = we_q;
      funct3_d = funct3_q;
      wdata_d  = wdata_q;
      phys_d   = phys_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      if (accept) begin
         we_d     = req_we;
         funct3_d = req_funct3;
         wdata_d  = req_wdata;
         phys_d   = req_phys;
         err_d    = req_err;
         rdata_d  = 32'h0;
      end else if (state_q == S_WAIT) begin
         rdata_d = we_q ? 32'h0 : load_data;
      end
   end

   // NOTE: request fields carry no reset; they are always loaded on acceptance before anything reads them.
   always_ff @(posedge clk) begin
      we_q     <= we_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      phys_q   <= phys_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu with a one-cycle-latency BRAM model.
// Honours DATA_MEM_LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_data_mem_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] memory_offset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        data_mem_clkb;
   logic        data_mem_enb;
   logic        data_mem_rstb;
   logic [3:0]  data_mem_web;
   logic [31:0] data_mem_addrb;
   logic [31:0] data_mem_dinb;
   logic [31:0] data_mem_doutb;
   logic        data_mem_rstb_busy;

   int total = 0;
   int bad   = 0;

   data_mem_lsu #(.MEM_DEPTH(4096)) dut (
      .clk               (clk),
      .reset             (reset),
      .memory_offset     (memory_offset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_we            (req_we),
      .req_funct3        (req_funct3),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_rdata         (rsp_rdata),
      .rsp_err           (rsp_err),
      .data_mem_clkb     (data_mem_clkb),
      .data_mem_enb      (data_mem_enb),
      .data_mem_rstb     (data_mem_rstb),
      .data_mem_web      (data_mem_web),
      .data_mem_addrb    (data_mem_addrb),
      .data_mem_dinb     (data_mem_dinb),
      .data_mem_doutb    (data_mem_doutb),
      .data_mem_rstb_busy(data_mem_rstb_busy)
   );

   always #5 clk = ~clk;

   // Read-first BRAM model with per-byte write enables and one cycle of read latency.
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (data_mem_enb) begin
         data_mem_doutb <= mem[data_mem_addrb[13:2]];
         for (int i = 0; i < 4; i++)
            if (data_mem_web[i]) mem[data_mem_addrb[13:2]][8*i +: 8] <= data_mem_dinb[8*i +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] r_rdata;
   logic        r_err;
   int          r_lat;
   logic        r_enb;
   logic [3:0]  r_web;
   logic [31:0] r_addrb;
   logic [31:0] r_dinb;
   logic        r_rdy_busy;

   // Issue one request, follow it to its response; r_lat counts cycles from acceptance to rsp_valid.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
      int n;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      tick();
      req_valid  = 1'b0;
      r_enb      = 1'b0;
      r_web      = 4'h0;
      r_addrb    = 32'h0;
      r_dinb     = 32'h0;
      r_rdy_busy = 1'b0;
      r_lat      = 1;
      while (1) begin
         if (data_mem_enb) begin
            r_enb   = 1'b1;
            r_web   = data_mem_web;
            r_addrb = data_mem_addrb;
            r_dinb  = data_mem_dinb;
         end
         if (req_ready) r_rdy_busy = 1'b1;
         if (rsp_valid || r_lat >= 20) break;
         tick();
         r_lat++;
      end
      r_rdata = rsp_rdata;
      r_err   = rsp_err;
      if (rsp_ready) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        stable_v, stable_d, rdy_low, any_enb, any_v;
      logic [31:0] held;

      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      data_mem_doutb     = 32'h0;
      reset              = 1'b1;
      memory_offset      = 32'h600;
      req_valid          = 1'b0;
      req_we             = 1'b0;
      req_funct3         = 3'b010;
      req_addr           = 32'h0;
      req_wdata          = 32'h0;
      rsp_ready          = 1'b1;
      data_mem_rstb_busy = 1'b0;

      // Reset state
      tick();
      tick();
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_rsp_err", rsp_err, 0);
      check("reset_enb", data_mem_enb, 0);
      check("reset_web", data_mem_web, 0);
      check("reset_addrb", data_mem_addrb, 0);
      check("reset_dinb", data_mem_dinb, 0);
      check("reset_rstb", data_mem_rstb, 0);
      reset = 1'b0;
      #1;
      check("post_reset_req_ready", req_ready, 1);

      // Word round-trip
      run_req(1'b1, 3'b010, 32'h604, 32'hDEADBEEF);
      check("sw_web", r_web, 4'b1111);
      check("sw_addrb", r_addrb, 32'h4);
      check("sw_dinb", r_dinb, 32'hDEADBEEF);
      check("sw_latency", r_lat, 3);
      check("sw_rdata_zero", r_rdata, 0);
      check("sw_err", r_err, 0);
      check("sw_ready_low_busy", r_rdy_busy, 0);
      run_req(1'b0, 3'b010, 32'h604, 32'h0);
      check("lw_web", r_web, 4'b0000);
      check("lw_addrb", r_addrb, 32'h4);
      check("lw_rdata", r_rdata, 32'hDEADBEEF);
      check("lw_latency", r_lat, 3);
      check("lw_err", r_err, 0);

      // Byte store into lane 3, then signed and unsigned byte loads
      run_req(1'b1, 3'b000, 32'h607, 32'h12345680);
      check("sb_web", r_web, 4'b1000);
      check("sb_dinb", r_dinb, 32'h80808080);
      run_req(1'b0, 3'b000, 32'h607, 32'h0);
      check("lb_rdata", r_rdata, 32'hFFFFFF80);
      run_req(1'b0, 3'b100, 32'h607, 32'h0);
      check("lbu_rdata", r_rdata, 32'h00000080);
      check("lbu_err", r_err, 0);

      // Half lanes on word 0x12348765 at physical 0x8
      run_req(1'b1, 3'b010, 32'h608, 32'h12348765);
      run_req(1'b0, 3'b001, 32'h60A, 32'h0);
      check("lh_hi_rdata", r_rdata, 32'h00001234);
      run_req(1'b0, 3'b001, 32'h608, 32'h0);
      check("lh_lo_rdata", r_rdata, 32'hFFFF8765);
      run_req(1'b0, 3'b101, 32'h608, 32'h0);
      check("lhu_lo_rdata", r_rdata, 32'h00008765);
      run_req(1'b0, 3'b000, 32'h609, 32'h0);
      check("lb_lane1_rdata", r_rdata, 32'hFFFFFF87);
      run_req(1'b1, 3'b001, 32'h60E, 32'h5555ABCD);
      check("sh_web", r_web, 4'b1100);
      check("sh_dinb", r_dinb, 32'hABCDABCD);

      // Range boundaries
      run_req(1'b1, 3'b010, 32'h45FC, 32'hCAFEF00D);
      check("last_word_sw_addrb", r_addrb, 32'h3FFC);
      check("last_word_sw_err", r_err, 0);
      run_req(1'b0, 3'b010, 32'h45FC, 32'h0);
      check("last_word_lw_rdata", r_rdata, 32'hCAFEF00D);
      run_req(1'b0, 3'b010, 32'h4600, 32'h0);
      check("oor_err", r_err, 1);
      check("oor_latency", r_lat, 1);
      check("oor_no_enb", r_enb, 0);
      check("oor_rdata", r_rdata, 0);
      run_req(1'b0, 3'b010, 32'h5FC, 32'h0);
      check("below_offset_err", r_err, 1);
      check("below_offset_no_enb", r_enb, 0);

      // Illegal funct3
      run_req(1'b1, 3'b100, 32'h604, 32'h11);
      check("sbu_err", r_err, 1);
      check("sbu_no_enb", r_enb, 0);
      run_req(1'b0, 3'b011, 32'h604, 32'h0);
      check("f3_011_err", r_err, 1);
      run_req(1'b0, 3'b010, 32'h604, 32'h0);
      check("err_cleared_next", r_err, 0);

      // Misaligned word (memory at 0x604 is 0x80ADBEEF after the byte store)
      run_req(1'b0, 3'b010, 32'h605, 32'h0);
`ifdef DATA_MEM_LSU_MISALIGN_TRAP_EN
      check("misalign_err", r_err, 1);
      check("misalign_no_enb", r_enb, 0);
      check("misalign_latency", r_lat, 1);
`else
      check("misalign_err", r_err, 0);
      check("misalign_rdata", r_rdata, 32'h80ADBEEF);
      check("misalign_addrb", r_addrb, 32'h4);
`endif

      // Backpressure: response held for 10 cycles
      rsp_ready = 1'b0;
      run_req(1'b0, 3'b010, 32'h608, 32'h0);
      check("bp_rdata", r_rdata, 32'h12348765);
      held     = rsp_rdata;
      stable_v = 1'b1;
      stable_d = 1'b1;
      rdy_low  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!rsp_valid) stable_v = 1'b0;
         if (rsp_rdata !== held) stable_d = 1'b0;
         if (req_ready) rdy_low = 1'b0;
      end
      check("bp_valid_stable", stable_v, 1);
      check("bp_rdata_stable", stable_d, 1);
      check("bp_req_ready_low", rdy_low, 1);
      rsp_ready = 1'b1;
      tick();
      check("bp_release_valid", rsp_valid, 0);
      check("bp_release_ready", req_ready, 1);

      // Reset while in WAIT
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h604;
      req_valid  = 1'b1;
      tick();
      req_valid = 1'b0;
      check("rst_wait_in_access", data_mem_enb, 1);
      tick();
      reset = 1'b1;
      tick();
      check("rst_wait_valid", rsp_valid, 0);
      check("rst_wait_ready_in_reset", req_ready, 0);
      reset = 1'b0;
      #1;
      check("rst_wait_ready_after", req_ready, 1);
      tick();
      check("rst_wait_discarded", rsp_valid, 0);
      check("rst_wait_rdata", rsp_rdata, 0);

      // rstb_busy blocks acceptance in IDLE
      data_mem_rstb_busy = 1'b1;
      #1;
      check("busy_req_ready", req_ready, 0);
      req_valid = 1'b1;
      any_enb   = 1'b0;
      any_v     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (data_mem_enb) any_enb = 1'b1;
         if (rsp_valid) any_v = 1'b1;
      end
      req_valid          = 1'b0;
      data_mem_rstb_busy = 1'b0;
      #1;
      check("busy_no_enb", any_enb, 0);
      check("busy_no_rsp", any_v, 0);
      check("busy_release_ready", req_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
